// File: rtl/mult_issue_ctrl_pkg.sv
// Shared execute-stage types and multiplier constants used by the multiply issue
// controller and its result FIFO.
package mult_issue_ctrl_pkg;

  localparam int MULT_LATENCY = 8;

  typedef struct packed {
    logic [7:0] op_id;
    logic [5:0] dest_tag;
  } IS_EX_PACKET;

  typedef struct packed {
    logic [63:0] alu_result;
    logic [7:0]  op_id;
    logic [5:0]  dest_tag;
  } EX_IC_PACKET;

endpackage

// File: rtl/mult_issue_ctrl_fifo.sv
// Result FIFO behind the multiplier: push on captured done, pop on handshake,
// clear on flush. The head is presented directly from the storage registers.
module mult_result_fifo
  import mult_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 10
) (
  input  logic                       clk,
  input  logic                       rst_n_i,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  EX_IC_PACKET                push_data_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       valid_o,
  output EX_IC_PACKET                head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  EX_IC_PACKET   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Pointer and occupancy next-state; clear overrides push and pop.
  always_comb begin
    do_pop_s = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      else        wr_ptr_d = wr_ptr_q;
      if (do_pop_s) rd_ptr_d = ptr_inc(rd_ptr_q);
      else          rd_ptr_d = rd_ptr_q;
      if (push_i && !do_pop_s)      count_d = count_q + CW'(1);
      else if (!push_i && do_pop_s) count_d = count_q - CW'(1);
      else                          count_d = count_q;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; entries need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  mult_result_fifo_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk     (clk),
    .rst_n_i (rst_n_i),
    .push_i  (push_i),
    .clear_i (clear_i),
    .count_i (count_q)
  );

endmodule

// Overflow checker: credits must keep the FIFO from ever being pushed while full.
module mult_result_fifo_chk #(
  parameter int DEPTH = 10,
  parameter int CW    = 4
) (
  input logic          clk,
  input logic          rst_n_i,
  input logic          push_i,
  input logic          clear_i,
  input logic [CW-1:0] count_i
);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n_i)
    (push_i && !clear_i) |-> (count_i < CW'(DEPTH)));
endmodule

// File: rtl/mult_issue_ctrl.sv
// Round-robin issue arbiter for the non-stalling pipelined multiplier; credits
// (in-flight + buffered) guarantee every completing result has a FIFO slot.
module mult_issue_ctrl
  import mult_issue_ctrl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DEPTH   = 10,
  parameter int LATENCY = MULT_LATENCY
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ-1:0][63:0]       req_mcand,
  input  logic [N_REQ-1:0][63:0]       req_mplier,
  input  IS_EX_PACKET [N_REQ-1:0]      req_packet,
  output logic [N_REQ-1:0]             grant,
  output logic                         mult_start,
  output logic [63:0]                  mult_mcand,
  output logic [63:0]                  mult_mplier,
  output IS_EX_PACKET                  mult_packet,
  input  logic                         mult_done,
  input  EX_IC_PACKET                  mult_result,
  output logic                         out_valid,
  output EX_IC_PACKET                  out_packet,
  input  logic                         out_ready,
  input  logic                         flush
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int SW    = CW + 1;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    inflight_q, inflight_d, discard_q, discard_d, count_s;
  logic [N_REQ-1:0] grant_s;
  logic [IDX_W-1:0] gnt_idx_s, cand_s;
  logic             gnt_any_s, hit_s, issue_ok_s, push_s;

  // Credit check and round-robin search starting at rr_ptr.
  always_comb begin
    issue_ok_s = !flush && ((SW'(inflight_q) + SW'(count_s)) < SW'(DEPTH));
    grant_s    = '0;
    gnt_idx_s  = '0;
    gnt_any_s  = 1'b0;
    cand_s     = '0;
    hit_s      = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_s = IDX_W'((int'(rr_ptr_q) + i) % N_REQ);
      hit_s  = issue_ok_s && !gnt_any_s && req[cand_s];
      if (hit_s) begin
        grant_s[cand_s] = 1'b1;
        gnt_idx_s       = cand_s;
        gnt_any_s       = 1'b1;
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
    if (!gnt_any_s)                          rr_ptr_d = rr_ptr_q;
    else if (gnt_idx_s == IDX_W'(N_REQ - 1)) rr_ptr_d = '0;
    else                                     rr_ptr_d = gnt_idx_s + IDX_W'(1);
  end

  // In-flight/discard accounting; dones that belong to squashed ops are dropped.
  always_comb begin
    if (gnt_any_s && !mult_done)      inflight_d = inflight_q + CW'(1);
    else if (!gnt_any_s && mult_done) inflight_d = inflight_q - CW'(1);
    else                              inflight_d = inflight_q;
    if (flush)                                discard_d = inflight_q - CW'(mult_done);
    else if (mult_done && discard_q != '0)    discard_d = discard_q - CW'(1);
    else                                      discard_d = discard_q;
    push_s = mult_done && !flush && (discard_q == '0);
  end

  // Arbiter and credit state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q   <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  assign grant       = grant_s;
  assign mult_start  = gnt_any_s;
  assign mult_mcand  = gnt_any_s ? req_mcand[gnt_idx_s]  : 64'd0;
  assign mult_mplier = gnt_any_s ? req_mplier[gnt_idx_s] : 64'd0;
  assign mult_packet = gnt_any_s ? req_packet[gnt_idx_s] : '0;

  mult_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n_i     (reset),
    .clear_i     (flush),
    .push_i      (push_s),
    .pop_i       (out_valid && out_ready),
    .push_data_i (mult_result),
    .count_o     (count_s),
    .valid_o     (out_valid),
    .head_o      (out_packet)
  );

  mult_issue_ctrl_chk #(.N_REQ(N_REQ), .LATENCY(LATENCY)) u_chk (
    .clk        (clk),
    .reset      (reset),
    .mult_start (gnt_any_s),
    .mult_done  (mult_done),
    .grant      (grant_s)
  );

endmodule

// Protocol checker: one-hot grant and fixed start-to-done pipeline latency.
module mult_issue_ctrl_chk #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 8
) (
  input logic             clk,
  input logic             reset,
  input logic             mult_start,
  input logic             mult_done,
  input logic [N_REQ-1:0] grant
);
  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(grant));
  a_fixed_latency: assert property (@(posedge clk) disable iff (!reset)
    mult_start |-> ##LATENCY mult_done);
endmodule
